// File: rtl/decoder_nx2n_seq_pkg.sv
// decoder_nx2n_seq_pkg: shared state type and one-hot helper for the sequenced decoder
package decoder_nx2n_seq_pkg;
  localparam int MAX_N = 8;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;
  function automatic logic [2**MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    onehot = '0;
    if (idx < (32'd1 << n)) onehot[idx[MAX_N-1:0]] = 1'b1;
  endfunction
endpackage

// File: rtl/decoder_nx2n_seq_dwell_counter.sv
// decoder_nx2n_seq_dwell_counter: counts dwell cycles in scan and flags the last one
module decoder_nx2n_seq_dwell_counter
  import decoder_nx2n_seq_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CW-1:0] cnt_q;
  assign tc_o = cnt_q == CW'(DWELL - 1);
  // Restart on clear, otherwise count up and roll over after the terminal cycle
  always_ff @(posedge clk)
    if (rst || clr_i) cnt_q <= '0;
    else cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/decoder_nx2n_seq.sv
// decoder_nx2n_seq: registered N-to-2^N one-hot decoder with direct and scan modes
module decoder_nx2n_seq
  import decoder_nx2n_seq_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL      = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   sel,
  output logic [2**N-1:0] y,
  output logic [N-1:0]   idx,
  output logic           valid,
  output logic           wrap
);
  localparam int W = 2**N;
  localparam logic [W-1:0] POL = {W{ACTIVE_LOW}};
  typedef logic [W-1:0] y_t;
  state_e state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [W-1:0] y_q, y_d;
  logic valid_q, valid_d, wrap_q, wrap_d, clr, tc;
  decoder_nx2n_seq_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr_i(clr),
    .tc_o (tc)
  );
  // Next state: disable beats mode; scan steps only while already scanning
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    clr     = 1'b1;
    if (!en) state_d = IDLE;
    else if (!mode) begin
      state_d = DIRECT;
      idx_d   = sel;
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      idx_d   = sel;
    end else begin
      clr = 1'b0;
      if (tc) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = &idx_q;
      end
    end
    valid_d = state_d != IDLE;
    y_d     = (valid_d ? y_t'(onehot(32'(idx_d), N)) : '0) ^ POL;
  end
  // State and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      y_q     <= POL;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// tb_decoder_nx2n_seq: scoreboard bench for three decoder configurations on shared stimulus
module tb_decoder_nx2n_seq;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] y0, y1;
  logic [3:0] y2;
  logic [2:0] idx0, idx1;
  logic [1:0] idx2;
  logic v0, v1, v2, w0, w1, w2;
  typedef struct {int st; int s; int k; int idx;} model_t;
  typedef struct {logic [7:0] y; int idx; bit v; bit w;} exp_t;
  model_t m[3];
  exp_t q0[$], q1[$], q2[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y0), .idx(idx0), .valid(v0), .wrap(w0));
  decoder_nx2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y1), .idx(idx1), .valid(v1), .wrap(w1));
  decoder_nx2n_seq #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]),
    .y(y2), .idx(idx2), .valid(v2), .wrap(w2));

  // Scan position = entry index + elapsed edges / dwell; wrap when a step lands on 0
  task automatic model_step(inout model_t mm, input int n, input int d, input bit al, output exp_t x);
    int lines, ni;
    lines = 1 << n;
    x.w = 1'b0;
    if (rst) begin mm.st = 0; mm.idx = 0; end
    else if (!en) mm.st = 0;
    else if (!mode) begin mm.st = 1; mm.idx = int'(sel) % lines; end
    else if (mm.st != 2) begin mm.st = 2; mm.s = int'(sel) % lines; mm.k = 0; mm.idx = mm.s; end
    else begin
      mm.k++;
      ni = (mm.s + mm.k / d) % lines;
      x.w = (mm.k % d == 0) && (ni == 0);
      mm.idx = ni;
    end
    x.v = mm.st != 0;
    x.idx = mm.idx;
    x.y = x.v ? 8'(1 << mm.idx) : 8'h00;
    if (al) x.y = x.y ^ 8'((1 << lines) - 1);
  endtask

  task automatic cyc(input bit r, input bit e, input bit md, input int sl);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = md; sel = 3'(sl);
    model_step(m[0], 3, 2, 1'b0, x); q0.push_back(x);
    model_step(m[1], 3, 1, 1'b1, x); q1.push_back(x);
    model_step(m[2], 2, 3, 1'b0, x); q2.push_back(x);
  endtask

  task automatic chk(input string nm, input exp_t x, input logic [7:0] y, input int id, input logic v, input logic w);
    checks++;
    if (y !== x.y || id != x.idx || v !== x.v || w !== x.w) begin
      errors++;
      $display("FAIL %s @%0t: got y=%h idx=%0d valid=%b wrap=%b, expected y=%h idx=%0d valid=%b wrap=%b",
               nm, $time, y, id, v, w, x.y, x.idx, x.v, x.w);
    end
  endtask

  // Monitor: every edge presents a registered output, compared against the queued expectation
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) chk("u0", q0.pop_front(), y0, int'(idx0), v0, w0);
    if (q1.size() > 0) chk("u1", q1.pop_front(), y1, int'(idx1), v1, w1);
    if (q2.size() > 0) chk("u2", q2.pop_front(), {4'h0, y2}, int'(idx2), v2, w2);
  end

  initial begin
    int md;
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
    repeat (2) cyc(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, i);
    cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 1, 1, 6);
    cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 1, 1, 3);
    cyc(0, 1, 0, 1);
    repeat (4) cyc(0, 1, 1, 1);
    repeat (3) cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 5);
    cyc(1, 1, 0, 5);
    cyc(0, 0, 0, 0);
    repeat (18) cyc(0, 1, 1, 0);
    md = 0;
    repeat (600) begin
      if ($urandom_range(0, 11) == 0) md = 1 - md;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, md != 0, int'($urandom_range(0, 7)));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_nx2n_seq.md
# decoder_nx2n_seq

Parametrised, registered N-to-2^N one-hot decoder with enable and two modes: direct decode of a select input, or autonomous scan where the active output walks through all 2^N lines with a programmable dwell. It succeeds the combinational 3-to-8 lab decoder. Typical uses are row/column strobe generation, display multiplexing and channel sequencing. It sits between control logic and the banks of loads it selects.

## Interface
- N, default 3: select width; output width is 2^N (N ≥ 1).
- DWELL, default 1: cycles each line stays active in scan mode (DWELL ≥ 1).
- ACTIVE_LOW, default 0: if 1, every bit of y is inverted. Inactive lines are 1 and the active line is 0.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; 0 forces idle on the next edge.
- mode  in  1  0 = direct decode, 1 = scan.
- sel  in  N  line index in direct mode; start index when scan is entered.
- y  out  2^N  registered one-hot output (polarity per ACTIVE_LOW).
- idx  out  N  index of the currently active line.
- valid  out  1  1 while a line is active.
- wrap  out  1  one-cycle pulse when scan wraps from 2^N-1 to 0.

## Operation
- States: IDLE, DIRECT, SCAN. A dwell counter `dcnt` of width clog2(DWELL), minimum 1 bit.
- Input precedence on every edge: rst > en=0 > mode.
- IDLE:
  - en=1, mode=0 → DIRECT, with idx=sel.
  - en=1, mode=1 → SCAN, with idx=sel and dcnt=0.
- DIRECT:
  - Each edge with en=1, mode=0: idx=sel. Sel may change every cycle.
  - en=1, mode=1 → SCAN, with idx=sel and dcnt=0.
  - en=0 → IDLE.
- SCAN:
  - Each edge, if dcnt == DWELL-1: dcnt=0 and idx=idx+1 mod 2^N. wrap=1 if the old idx was 2^N-1.
  - Otherwise dcnt increments and idx holds.
  - sel is ignored while in SCAN.
  - mode=0 → DIRECT, with idx=sel (the current sel, no scan step). en=0 → IDLE.
- Outputs in DIRECT/SCAN: y = onehot(idx), valid=1.
- Outputs in IDLE: y = all lines inactive, valid=0, idx holds its last value.
- wrap is 0 on every edge that does not perform the 2^N-1→0 step, including any state change.
- ACTIVE_LOW affects y only. Values in the rest of this spec are written for ACTIVE_LOW=0.

## Timing
- All outputs are registered. Inputs sampled at edge k appear on the outputs after edge k (1-cycle latency).
- Reset values: state=IDLE, y=0 (all ones if ACTIVE_LOW), idx=0, valid=0, wrap=0, dcnt=0.
- Reset mid-scan: outputs return to the reset values after that edge. The scan position is lost.
- Scan with DWELL=D: each index is held exactly D cycles. The first index after entry (=sel) is also held D cycles. A full sweep takes D·2^N cycles.
- wrap is asserted in the same cycle that idx=0 and y=onehot(0) first appear after a wrap.
- Mode switch SCAN→DIRECT→SCAN restarts the dwell at 0 from the current sel.

## Structure
- Shared package: state enum (IDLE, DIRECT, SCAN) and a one-hot decode function onehot(idx, N).
- A natural sub-module is `dwell_counter` (DWELL-parameterised, clear input, terminal-count output). It drives the scan step.
- Everything else stays flat in one module.

## Test plan
All scenarios use N=3, DWELL=2, ACTIVE_LOW=0 unless stated.
- Reset: rst=1 for 2 cycles with en=1 → y=0x00, idx=0, valid=0, wrap=0. Repeat with ACTIVE_LOW=1 → y=0xFF.
- Direct decode: en=1, mode=0, sel driven 0..7 on consecutive cycles → one cycle later y=0x01,0x02,…,0x80, idx tracks sel, valid=1. Then en=0 → next cycle y=0x00, valid=0.
- Scan with wrap: en=1, mode=1, sel=6 → y=0x40 for 2 cycles, 0x80 for 2 cycles, then 0x01 with wrap=1 for exactly one cycle, then 0x01 again with wrap=0.
- Dwell of one: DWELL=1, sel=0, scan → y walks 0x01..0x80, one line per cycle. wrap pulses every 8 cycles.
- Mode switch mid-scan: scanning at idx=3 with dcnt=1, set mode=0 with sel=1 → next cycle y=0x02, wrap=0. Then mode=1 → y=0x02 held 2 cycles, then 0x04.
- Disruption: en=0 mid-scan → next cycle idle outputs. rst=1 while in DIRECT at sel=5 → next cycle idx=0, y=0x00.
